// File: rtl/buffer_port_arbiter_pkg.sv
// buffer_port_arbiter_pkg: shared types and constants for the buffer port arbiter.
// The clock/reset record, the request payload struct and the read-detect helper
// live here so the arbiter, its interface and the bench agree on one definition.
package buffer_port_arbiter_pkg;

    // Clock/reset record: single clock plus asynchronous active-high reset.
    typedef struct packed {
        logic clk;
        logic reset;
    } ckrs_t;

    // Payload widths of the request struct. The top level casts its own AW/DW
    // onto these fields, so widen them here if the buffer ever grows past 32 bits.
    localparam int BUF_AW = 32;
    localparam int BUF_DW = 32;

    // Byte write enables of all zero mean "read".
    localparam logic [3:0] BUF_WE_NONE = 4'b0000;

    // One request payload as presented to the shared buffer port.
    typedef struct packed {
        logic [BUF_AW-1:0] addr;
        logic [BUF_DW-1:0] din;
        logic [3:0]        we;
    } buf_req_t;

    // True when a payload is a read rather than a write.
    function automatic logic isRead(input logic [3:0] we);
        return (we == BUF_WE_NONE);
    endfunction

endpackage

// File: rtl/buffer_port_arbiter_if.sv
// buffer_port_arbiter_if: the bundle toward the single-port block-RAM buffer.
// The arbiter uses the master modport (drives en/addr/din/we, receives dout);
// the buffer model or RAM wrapper uses the slave modport.
interface buffer_port_arbiter_if
    import buffer_port_arbiter_pkg::*;
#(
    parameter int AW = BUF_AW,
    parameter int DW = BUF_DW
);
    logic          en;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [3:0]    we;
    logic [DW-1:0] dout;

    modport master (
        output en,
        output addr,
        output din,
        output we,
        input  dout
    );

    modport slave (
        input  en,
        input  addr,
        input  din,
        input  we,
        output dout
    );
endinterface

// File: rtl/buffer_port_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin pointer plus one-hot grant for the buffer port arbiter.
// The grant is purely combinational from req_i and the pointer; the pointer moves
// one past the winner whenever the owner of the port reports a completed transfer.
module rr_arbiter
    import buffer_port_arbiter_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  ckrs_t            ClkRs_ix,
    input  logic [N_REQ-1:0] req_i,
    input  logic             advance_i,
    output logic [N_REQ-1:0] gnt_o
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic          clk;
    logic          rst;
    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] winIdx;
    logic          found;
    int            idx;

    assign clk = ClkRs_ix.clk;
    assign rst = ClkRs_ix.reset;

    // Scan requesters starting at the pointer, wrapping once, and grant the first one asserting req.
    always_comb begin
        gnt_o  = '0;
        winIdx = ptr_q;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                winIdx     = PW'(idx);
            end
        end
    end

    // After a transfer the winner drops to lowest priority; with no transfer the pointer holds.
    always_comb begin
        ptr_d = ptr_q;
        if (advance_i) begin
            if (winIdx == PW'(N_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = winIdx + PW'(1);
            end
        end
    end

    // Pointer register, cleared to requester 0 on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/buffer_port_arbiter.sv
// buffer_port_arbiter: shares one single-port block-RAM buffer port between N_REQ
// requesters with round-robin arbitration. Accepted requests are issued to the
// buffer one cycle later; reads return a one-hot strobe RD_LATENCY cycles after
// their issue cycle, with rdata_o taken straight from the buffer output.
// Optional per-requester grant counters are built when BUFFER_ARB_STATS_EN is defined.
module buffer_port_arbiter
    import buffer_port_arbiter_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int RD_LATENCY = 2,
    parameter int AW         = BUF_AW,
    parameter int DW         = BUF_DW
) (
    input  ckrs_t                       ClkRs_ix,
    input  logic [N_REQ-1:0]            req_i,
    input  logic [N_REQ-1:0][AW-1:0]    addr_i,
    input  logic [N_REQ-1:0][DW-1:0]    din_i,
    input  logic [N_REQ-1:0][3:0]       we_i,
    output logic [N_REQ-1:0]            gnt_o,
    output logic [N_REQ-1:0]            rvalid_o,
    output logic [DW-1:0]               rdata_o,
    buffer_port_arbiter_if.master       bufPort
`ifdef BUFFER_ARB_STATS_EN
    ,
    input  logic                        stats_clr_i,
    output logic [N_REQ-1:0][15:0]      grant_cnt_o
`endif
);

    logic                              clk;
    logic                              rst;
    logic                              transfer;
    buf_req_t                          selReq;

    logic                              issueEn_q;
    logic                              issueEn_d;
    logic [AW-1:0]                     issueAddr_q;
    logic [AW-1:0]                     issueAddr_d;
    logic [DW-1:0]                     issueDin_q;
    logic [DW-1:0]                     issueDin_d;
    logic [3:0]                        issueWe_q;
    logic [3:0]                        issueWe_d;
    logic [N_REQ-1:0]                  issueTag_q;
    logic [N_REQ-1:0]                  issueTag_d;

    logic [RD_LATENCY-1:0][N_REQ-1:0]  tagPipe_q;
    logic [RD_LATENCY-1:0][N_REQ-1:0]  tagPipe_d;

    assign clk = ClkRs_ix.clk;
    assign rst = ClkRs_ix.reset;

    rr_arbiter #(
        .N_REQ     (N_REQ)
    ) u_rr_arbiter (
        .ClkRs_ix  (ClkRs_ix),
        .req_i     (req_i),
        .advance_i (transfer),
        .gnt_o     (gnt_o)
    );

    assign transfer = |(req_i & gnt_o);

    // Select the granted requester's payload; the grant is one-hot so at most one term fires.
    always_comb begin
        selReq = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_o[i]) begin
                selReq.addr = BUF_AW'(addr_i[i]);
                selReq.din  = BUF_DW'(din_i[i]);
                selReq.we   = we_i[i];
            end
        end
    end

    // Next issue state: load the winner on a transfer, otherwise idle the port but keep addr/din.
    always_comb begin
        issueEn_d   = transfer;
        issueAddr_d = issueAddr_q;
        issueDin_d  = issueDin_q;
        issueWe_d   = BUF_WE_NONE;
        issueTag_d  = '0;
        if (transfer) begin
            issueAddr_d = AW'(selReq.addr);
            issueDin_d  = DW'(selReq.din);
            issueWe_d   = selReq.we;
            if (isRead(selReq.we)) begin
                issueTag_d = gnt_o;
            end
        end
    end

    // Shift read tags along so each one surfaces RD_LATENCY cycles after its issue cycle.
    always_comb begin
        tagPipe_d    = tagPipe_q;
        tagPipe_d[0] = issueTag_q;
        for (int k = 1; k < RD_LATENCY; k++) begin
            tagPipe_d[k] = tagPipe_q[k-1];
        end
    end

    // Issue registers and tag pipe; reset discards any reads still in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issueEn_q   <= 1'b0;
            issueAddr_q <= '0;
            issueDin_q  <= '0;
            issueWe_q   <= BUF_WE_NONE;
            issueTag_q  <= '0;
            tagPipe_q   <= '0;
        end else begin
            issueEn_q   <= issueEn_d;
            issueAddr_q <= issueAddr_d;
            issueDin_q  <= issueDin_d;
            issueWe_q   <= issueWe_d;
            issueTag_q  <= issueTag_d;
            tagPipe_q   <= tagPipe_d;
        end
    end

    assign bufPort.en   = issueEn_q;
    assign bufPort.addr = issueAddr_q;
    assign bufPort.din  = issueDin_q;
    assign bufPort.we   = issueWe_q;

    assign rvalid_o = tagPipe_q[RD_LATENCY-1];
    assign rdata_o  = bufPort.dout;

`ifdef BUFFER_ARB_STATS_EN
    logic [N_REQ-1:0][15:0] grantCnt_q;
    logic [N_REQ-1:0][15:0] grantCnt_d;

    // Per-requester transfer counters: clear wins over increment, counting stops at 0xFFFF.
    always_comb begin
        grantCnt_d = grantCnt_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (stats_clr_i) begin
                grantCnt_d[i] = 16'h0000;
            end else if (req_i[i] && gnt_o[i] && (grantCnt_q[i] != 16'hFFFF)) begin
                grantCnt_d[i] = grantCnt_q[i] + 16'h0001;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grantCnt_q <= '0;
        end else begin
            grantCnt_q <= grantCnt_d;
        end
    end

    assign grant_cnt_o = grantCnt_q;
`endif

endmodule

// File: doc/buffer_port_arbiter.md
Name: buffer_port_arbiter

Overview:
- Shares one single-port block-RAM buffer port between N_REQ independent requesters using round-robin arbitration.
- The buffer side drives the consumer-side signals of the design's buffer bundle: en, addr, din, we out; dout in.
- Each requester sees a valid/ready request channel and a tagged read-return channel.
- Sits between the register/diagnostic logic (e.g. motor status capture and the RS485 command engine) and the shared buffer.

Parameters:
N_REQ, 4, number of requesters (2..8)
RD_LATENCY, 2, cycles from buffer en/addr cycle to valid buf_dout_i (1..4)
AW, 32, address width
DW, 32, data width

Ports:
ClkRs_ix  input  ckrs_t  clock/reset record; .clk single clock; .reset asynchronous, active-high
req_i  input  N_REQ  per-requester request valid
addr_i  input  N_REQ x AW  request address
din_i  input  N_REQ x DW  write data
we_i  input  N_REQ x 4  byte write enables; all-zero = read
gnt_o  output  N_REQ  one-hot ready; transfer when req_i[i] & gnt_o[i] at rising edge
rvalid_o  output  N_REQ  one-hot read-return strobe
rdata_o  output  DW  read-return data
buf_en_o  output  1  buffer enable
buf_addr_o  output  AW  buffer address
buf_din_o  output  DW  buffer write data
buf_we_o  output  4  buffer byte write enables
buf_dout_i  input  DW  buffer read data

Behaviour:
- Arbitration:
  - gnt_o is combinational from req_i and the round-robin pointer ptr (0..N_REQ-1).
  - Search starts at ptr, wraps modulo N_REQ; the first requester with req_i high is granted. At most one gnt_o bit is high.
  - gnt_o does not depend on addr_i, din_i or we_i.
  - On a transfer to index w: ptr <= (w+1) mod N_REQ. No request: ptr holds.
- Issue: registered, 1 cycle after acceptance.
  - After the accepting edge, buf_en_o=1 and buf_addr_o/buf_din_o/buf_we_o carry the winner's payload.
  - With no transfer, buf_en_o=0 and buf_we_o=0; buf_addr_o and buf_din_o hold their last values.
  - Back-to-back issue every cycle is supported (100% throughput).
- Read return:
  - A read (we_i==0) pushes a one-hot tag into a RD_LATENCY-deep shift pipe.
  - rvalid_o[w]=1 exactly RD_LATENCY cycles after its buf_en_o cycle, for one cycle.
  - rdata_o = buf_dout_i (combinational passthrough); it is meaningful only when rvalid_o is non-zero.
  - Writes produce no rvalid_o. Return order equals issue order.
- Requester rules:
  - A requester must hold req_i and its payload stable until handshake.
  - A requester may deassert req_i without penalty before it is granted.
- Reset (async assert, sync release): ptr=0, buf_en_o=0, buf_we_o=0, buf_addr_o=0, buf_din_o=0, tag pipe cleared, rvalid_o=0. In-flight reads are discarded and never returned.
- Simultaneous requests: granted in rotation from ptr. No requester waits more than N_REQ-1 transfers while holding req_i.
- Read and write to the same address in consecutive cycles: ordering follows issue order. Read-during-write semantics are those of the buffer itself.

Optional Feature:
- Macro BUFFER_ARB_STATS_EN.
- Defined:
  - Adds output grant_cnt_o, N_REQ x 16: per-requester transfer counters.
  - Counters saturate at 0xFFFF and reset to 0.
  - Adds input stats_clr_i: synchronous clear of all counters. A clear takes priority over an increment in the same cycle.
- Undefined: the port, counters and clear logic are absent; all other behaviour is identical.

Decomposition:
- Package types:
  - buf_req_t struct {addr AW, din DW, we 4}.
  - Constant BUF_WE_NONE = 4'b0.
- Sub-module rr_arbiter holds the pointer register and the one-hot grant logic.
  - Parameter: N_REQ.
  - Inputs: clk/reset record, req, advance.
  - Output: gnt.
- The top level holds the payload mux, the issue registers, the tag pipe and the optional stats counters.

Test Plan:
- Reset, then a single read by req 2 at 0x10 with buf_dout_i=0xCAFE0010 -> gnt_o=4'b0100 same cycle; buf_en_o=1, buf_addr_o=0x10 next cycle; rvalid_o=4'b0100 with rdata_o=0xCAFE0010 RD_LATENCY cycles later.
- All 4 requesters held high for 8 cycles from ptr=0 -> grant order 0,1,2,3,0,1,2,3; buf_en_o high every cycle.
- Write by req 1 (we=4'hF, addr 0x4, din 0x12345678) followed by a read by req 1 -> buf_we_o=4'hF then 4'h0; exactly one rvalid_o[1] pulse, for the read only.
- Req 3 holds while req 0 toggles every cycle, starting at ptr=0 -> req 3 is granted within 2 transfers; req 0 is never granted twice in a row while req 3 waits.
- Reset asserted with 2 reads in flight -> outputs zero immediately; no rvalid_o after release; the first request after release is arbitrated from ptr=0.
- BUFFER_ARB_STATS_EN: 70000 grants to req 0 -> grant_cnt_o[0]=0xFFFF. stats_clr_i and a grant in the same cycle -> counter reads 0.
